otter_cu_fsm: RTL

Multicycle sequencing controller for the OTTER RV32I core. Steps each instruction through fetch, execute, optional load writeback and interrupt entry, and emits the per-cycle write/read strobes that gate the PC, register file, memory and CSR file. It sits beside the combinational control-unit decoder: the decoder chooses mux selects and ALU function, and this block decides when state is committed. It also owns the pending-interrupt latch and the memory-ready wait handshake.

---
 rtl/otter_cu_fsm_if.sv | 31 +++
 rtl/otter_cu_fsm.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/otter_cu_fsm_if.sv
// Sequencing-controller bus: decoder/CSR/memory inputs and the commit strobes.
// The controller takes the slave side; the surrounding core drives the master side.
interface otter_cu_fsm_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       intr;
    logic       mie;
    logic       mem_ready;
    logic       rst_pc;
    logic       pc_write;
    logic       reg_write;
    logic       mem_rden1;
    logic       mem_rden2;
    logic       mem_we2;
    logic       csr_we;
    logic       int_taken;
    logic       mret_exec;
    logic [2:0] state_o;

    modport slave (
        input  opcode, funct3, intr, mie, mem_ready,
        output rst_pc, pc_write, reg_write, mem_rden1, mem_rden2,
               mem_we2, csr_we, int_taken, mret_exec, state_o
    );

    modport master (
        output opcode, funct3, intr, mie, mem_ready,
        input  rst_pc, pc_write, reg_write, mem_rden1, mem_rden2,
               mem_we2, csr_we, int_taken, mret_exec, state_o
    );
endinterface

// File: rtl/otter_cu_fsm.sv
// OTTER multicycle sequencer: fetch / execute / load writeback / trap entry,
// producing the commit strobes and owning the pending-interrupt latch.
module otter_cu_fsm (
    input  logic            clk,
    input  logic            rst_n,
    otter_cu_fsm_if.slave   bus
);
    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_INTR  = 3'd4
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    state_t r_state;
    state_t w_next;
    logic   r_pend;
    logic   w_take;

    logic w_rst_pc;
    logic w_pc_write;
    logic w_reg_write;
    logic w_mem_rden1;
    logic w_mem_rden2;
    logic w_mem_we2;
    logic w_csr_we;
    logic w_int_taken;
    logic w_mret_exec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    // Sticky until trap entry completes; the clear wins over a same-cycle request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= 1'b0;
        end else if (r_state == ST_INTR) begin
            r_pend <= 1'b0;
        end else if (bus.intr) begin
            r_pend <= 1'b1;
        end
    end

    // The live request is ORed in so an interrupt coinciding with retire is not lost.
    assign w_take = (r_pend | bus.intr) & bus.mie;

    always_comb begin
        w_next      = ST_INIT;
        w_rst_pc    = 1'b0;
        w_pc_write  = 1'b0;
        w_reg_write = 1'b0;
        w_mem_rden1 = 1'b0;
        w_mem_rden2 = 1'b0;
        w_mem_we2   = 1'b0;
        w_csr_we    = 1'b0;
        w_int_taken = 1'b0;
        w_mret_exec = 1'b0;

        case (r_state)
            ST_INIT: begin
                w_rst_pc = 1'b1;
                w_next   = ST_FETCH;
            end

            ST_FETCH: begin
                w_mem_rden1 = 1'b1;
                w_next      = bus.mem_ready ? ST_EXEC : ST_FETCH;
            end

            ST_EXEC: begin
                w_next = w_take ? ST_INTR : ST_FETCH;
                case (bus.opcode)
                    OP_LOAD: begin
                        w_mem_rden2 = 1'b1;
                        w_next      = ST_WB;
                    end
                    OP_STORE: begin
                        w_mem_we2  = 1'b1;
                        w_pc_write = 1'b1;
                    end
                    OP_BRANCH: begin
                        w_pc_write = 1'b1;
                    end
                    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_REG: begin
                        w_reg_write = 1'b1;
                        w_pc_write  = 1'b1;
                    end
                    OP_SYSTEM: begin
                        w_pc_write = 1'b1;
                        if (bus.funct3 == 3'b000) begin
                            w_mret_exec = 1'b1;
                        end else begin
                            w_csr_we    = 1'b1;
                            w_reg_write = 1'b1;
                        end
                    end
                    default: begin
                        w_pc_write = 1'b1;
                    end
                endcase
            end

            ST_WB: begin
                w_mem_rden2 = 1'b1;
                if (bus.mem_ready) begin
                    w_reg_write = 1'b1;
                    w_pc_write  = 1'b1;
                    w_next      = w_take ? ST_INTR : ST_FETCH;
                end else begin
                    w_next = ST_WB;
                end
            end

            ST_INTR: begin
                w_int_taken = 1'b1;
                w_pc_write  = 1'b1;
                w_next      = ST_FETCH;
            end

            default: begin
                w_next = ST_INIT;
            end
        endcase
    end

    assign bus.rst_pc    = w_rst_pc;
    assign bus.pc_write  = w_pc_write;
    assign bus.reg_write = w_reg_write;
    assign bus.mem_rden1 = w_mem_rden1;
    assign bus.mem_rden2 = w_mem_rden2;
    assign bus.mem_we2   = w_mem_we2;
    assign bus.csr_we    = w_csr_we;
    assign bus.int_taken = w_int_taken;
    assign bus.mret_exec = w_mret_exec;
    assign bus.state_o   = r_state;
endmodule
